uart_tx_frame: RTL and testbench

Configurable UART transmitter: serialises one character per frame onto `o_tx`. Framing is set at run time: 6/7/8 data bits, none/even/odd parity, and 1/1.5/2 stop bits. Bit timing comes from a shared 16x-oversampling baud tick, and the start input is level-sensitive. The block sits between the TX FIFO read port (start = FIFO not empty, done tick = FIFO pop) and the serial line. It mirrors the framing rules of the receiver.

---
 rtl/uart_tx_frame.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Run-time configurable UART transmitter. Sends one character per frame on
// o_tx: a start bit, 6/7/8 data bits (LSB first), an optional even/odd parity
// bit and 1, 1.5 or 2 stop bits. Bit timing is counted in baud ticks
// (SB_TICK_UNIT ticks per bit). The block is meant to sit on a TX FIFO read
// port: i_tx_start is "FIFO not empty", o_tx_done_tick is the FIFO pop.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         asynchronous, active-high reset
//   i_baud_tick     one-clock pulse at SB_TICK_UNIT x the bit rate
//   i_tx_start      level: a character is available
//   i_data          character, only the low N bits are sent
//   i_data_num      00: 6 bits, 01: 7 bits, 1x: 8 bits
//   i_stop_num      00: 1 stop, 01: 1.5 stop, 1x: 2 stop bits
//   i_par           01: even, 10: odd, 00/11: no parity
//   o_tx            serial line, registered, idles high
//   o_tx_done_tick  one-clock pulse in the first IDLE clock after the frame
//   o_busy          high for exactly the clocks o_tx carries the frame
//
// All outputs are registered from the current FSM state, so the line lags
// the FSM by one clock: o_tx falls one clock after the edge that samples
// i_tx_start, and the done pulse coincides with the last stop-bit clock on
// the line. Configuration and data are latched on the IDLE -> START edge and
// never looked at again until the next frame.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int DBIT_MAX     = 8,
   parameter int SB_TICK_UNIT = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_baud_tick,
   input  logic                i_tx_start,
   input  logic [DBIT_MAX-1:0] i_data,
   input  logic [1:0]          i_data_num,
   input  logic [1:0]          i_stop_num,
   input  logic [1:0]          i_par,
   output logic                o_tx,
   output logic                o_tx_done_tick,
   output logic                o_busy
);

   // Tick counter must reach 2*SB_TICK_UNIT-1 for two stop bits.
   localparam int S_W = $clog2(2 * SB_TICK_UNIT);
   localparam int N_W = $clog2(DBIT_MAX);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [S_W-1:0] S_BIT_LAST    = S_W'(SB_TICK_UNIT - 1);
   localparam logic [S_W-1:0] S_STOP15_LAST = S_W'(SB_TICK_UNIT + SB_TICK_UNIT / 2 - 1);
   localparam logic [S_W-1:0] S_STOP2_LAST  = S_W'(2 * SB_TICK_UNIT - 1);
   localparam logic [S_W-1:0] S_ONE         = S_W'(1);
   localparam logic [N_W-1:0] N_ONE         = N_W'(1);

   logic [2:0]          state_q,   state_d;
   logic [S_W-1:0]      s_q,       s_d;        // baud ticks within current bit
   logic [N_W-1:0]      n_q,       n_d;        // data bit index
   logic [DBIT_MAX-1:0] b_q,       b_d;        // shift register, b_q[0] is on the line
   logic [N_W-1:0]      n_last_q,  n_last_d;   // latched N-1
   logic                par_en_q,  par_en_d;
   logic                par_odd_q, par_odd_d;
   logic [S_W-1:0]      t_last_q,  t_last_d;   // latched stop ticks T-1
   logic                par_acc_q, par_acc_d;  // XOR of data bits sent so far
   logic                tx_q,      tx_d;
   logic                done_q,    done_d;
   logic                busy_q,    busy_d;

   // Decoded configuration, only used on the IDLE -> START edge.
   logic [N_W-1:0]      cfg_n_last;
   logic [S_W-1:0]      cfg_t_last;
   logic                cfg_par_en;
   logic                cfg_par_odd;

   // Tick that closes a full-length bit (start, data or parity).
   logic                bit_end;

   always_comb begin
      case (i_data_num)
         2'b00:   cfg_n_last = N_W'(5);
         2'b01:   cfg_n_last = N_W'(6);
         default: cfg_n_last = N_W'(7);
      endcase

      case (i_stop_num)
         2'b00:   cfg_t_last = S_BIT_LAST;
         2'b01:   cfg_t_last = S_STOP15_LAST;
         default: cfg_t_last = S_STOP2_LAST;
      endcase

      cfg_par_en  = (i_par == 2'b01) || (i_par == 2'b10);
      cfg_par_odd = (i_par == 2'b10);
   end

   assign bit_end = i_baud_tick && (s_q == S_BIT_LAST);

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      b_d       = b_q;
      n_last_d  = n_last_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      t_last_d  = t_last_q;
      par_acc_d = par_acc_q;
      tx_d      = 1'b1;
      done_d    = 1'b0;
      // Busy follows the state with the same one-clock lag as the line.
      busy_d    = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            // Starts on the clock edge itself, not on a baud tick.
            if (i_tx_start) begin
               b_d       = i_data;
               n_last_d  = cfg_n_last;
               par_en_d  = cfg_par_en;
               par_odd_d = cfg_par_odd;
               t_last_d  = cfg_t_last;
               par_acc_d = 1'b0;
               s_d       = '0;
               n_d       = '0;
               state_d   = ST_START;
            end
         end

         ST_START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               s_d     = '0;
               state_d = ST_DATA;
            end else if (i_baud_tick) begin
               s_d = s_q + S_ONE;
            end
         end

         ST_DATA: begin
            tx_d = b_q[0];
            if (bit_end) begin
               s_d       = '0;
               b_d       = b_q >> 1;
               par_acc_d = par_acc_q ^ b_q[0];
               if (n_q == n_last_q) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  n_d = n_q + N_ONE;
               end
            end else if (i_baud_tick) begin
               s_d = s_q + S_ONE;
            end
         end

         ST_PARITY: begin
            // Accumulator is even parity; odd mode inverts it.
            tx_d = par_acc_q ^ par_odd_q;
            if (bit_end) begin
               s_d     = '0;
               state_d = ST_STOP;
            end else if (i_baud_tick) begin
               s_d = s_q + S_ONE;
            end
         end

         ST_STOP: begin
            tx_d = 1'b1;
            if (i_baud_tick) begin
               if (s_q == t_last_q) begin
                  s_d     = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            s_d     = '0;
            n_d     = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         s_q       <= '0;
         n_q       <= '0;
         b_q       <= '0;
         n_last_q  <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         t_last_q  <= '0;
         par_acc_q <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         b_q       <= b_d;
         n_last_q  <= n_last_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         t_last_q  <= t_last_d;
         par_acc_q <= par_acc_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign o_tx           = tx_q;
   assign o_tx_done_tick = done_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Directed bench for uart_tx_frame. Each scenario task launches a frame,
// logs o_tx / o_tx_done_tick / o_busy once per clock (on the falling edge;
// log index k is the value seen after rising edge E_k, E_0 being the edge
// that samples i_tx_start) and compares against expected waveforms built
// from hand-written bit sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

   localparam int LOG_N = 1024;

   typedef int seq_t [8];

   logic       clk;
   logic       i_reset;
   logic       i_baud_tick;
   logic       i_tx_start;
   logic [7:0] i_data;
   logic [1:0] i_data_num;
   logic [1:0] i_stop_num;
   logic [1:0] i_par;
   logic       o_tx;
   logic       o_tx_done_tick;
   logic       o_busy;

   logic tx_log   [LOG_N];
   logic done_log [LOG_N];
   logic busy_log [LOG_N];
   logic exp_tx   [LOG_N];
   logic exp_done [LOG_N];
   logic exp_busy [LOG_N];

   int cyc;
   int n_checks;
   int n_pass;

   uart_tx_frame #(
      .DBIT_MAX     (8),
      .SB_TICK_UNIT (16)
   ) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_baud_tick    (i_baud_tick),
      .i_tx_start     (i_tx_start),
      .i_data         (i_data),
      .i_data_num     (i_data_num),
      .i_stop_num     (i_stop_num),
      .i_par          (i_par),
      .o_tx           (o_tx),
      .o_tx_done_tick (o_tx_done_tick),
      .o_busy         (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: sample outputs into the log, then set the tick for the next edge.
   task automatic step(input int period);
      @(negedge clk);
      if (cyc < LOG_N) begin
         tx_log[cyc]   = o_tx;
         done_log[cyc] = o_tx_done_tick;
         busy_log[cyc] = o_busy;
      end
      cyc++;
      i_baud_tick = ((cyc % period) == 0);
   endtask

   task automatic clear_expect();
      for (int k = 0; k < LOG_N; k++) begin
         exp_tx[k]   = 1'b1;
         exp_done[k] = 1'b0;
         exp_busy[k] = 1'b0;
      end
   endtask

   // Expected line for a frame with one baud tick per clock whose start is
   // sampled on edge E_base. par_bit < 0 means no parity bit.
   task automatic build_expect(input int base, input seq_t seq, input int nbits,
                               input int par_bit, input int stop_ticks);
      int k;
      int last;
      k = base + 1;
      for (int i = 0; i < 16; i++) exp_tx[k + i] = 1'b0;
      k += 16;
      for (int b = 0; b < nbits; b++) begin
         for (int i = 0; i < 16; i++) exp_tx[k + i] = (seq[b] != 0);
         k += 16;
      end
      if (par_bit >= 0) begin
         for (int i = 0; i < 16; i++) exp_tx[k + i] = (par_bit != 0);
         k += 16;
      end
      last = k + stop_ticks - 1;
      for (int j = base + 1; j <= last; j++) exp_busy[j] = 1'b1;
      exp_done[last] = 1'b1;
   endtask

   function automatic logic got_bit(input int w, input int k);
      if (w == 0) return tx_log[k];
      if (w == 1) return done_log[k];
      return busy_log[k];
   endfunction

   function automatic logic exp_bit(input int w, input int k);
      if (w == 0) return exp_tx[k];
      if (w == 1) return exp_done[k];
      return exp_busy[k];
   endfunction

   function automatic string wave_name(input int w);
      if (w == 0) return "tx";
      if (w == 1) return "done";
      return "busy";
   endfunction

   function automatic int first_diff(input int w, input int len);
      for (int k = 0; k < len; k++) begin
         if (got_bit(w, k) !== exp_bit(w, k)) return k;
      end
      return -1;
   endfunction

   function automatic int first_done(input int len);
      for (int k = 0; k < len; k++) begin
         if (done_log[k] === 1'b1) return k;
      end
      return -1;
   endfunction

   task automatic start_frame(input logic [7:0] data, input logic [1:0] dn,
                              input logic [1:0] sn, input logic [1:0] par,
                              input int period);
      @(negedge clk);
      i_data      = data;
      i_data_num  = dn;
      i_stop_num  = sn;
      i_par       = par;
      i_tx_start  = 1'b1;
      i_baud_tick = (period == 1);
      cyc         = 0;
      clear_expect();
   endtask

   task automatic test_reset();
      int ones;
      i_reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (o_tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", o_tx); else n_pass++;
      n_checks++;
      if (o_tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_tx_done_tick); else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
      i_reset = 1'b0;
      cyc = 0;
      repeat (4) step(1);
      ones = 0;
      for (int k = 0; k < 4; k++) if (tx_log[k] === 1'b1 && busy_log[k] === 1'b0) ones++;
      n_checks++;
      if (ones !== 4) $display("FAIL idle_line: idle-high clocks %0d expected 4", ones); else n_pass++;
      $display("reset: o_tx=%b done=%b busy=%b", o_tx, o_tx_done_tick, o_busy);
   endtask

   // Shared tail of the single-frame tests: compare the three waveforms.
   task automatic compare_waves(input string tag, input int len);
      int idx;
      for (int w = 0; w < 3; w++) begin
         idx = first_diff(w, len);
         n_checks++;
         if (idx !== -1)
            $display("FAIL %s_%s: cycle %0d got %b expected %b", tag, wave_name(w),
                     idx, got_bit(w, idx), exp_bit(w, idx));
         else
            n_pass++;
      end
   endtask

   task automatic test_8n1();
      int d;
      start_frame(8'hA5, 2'b10, 2'b00, 2'b00, 1);
      step(1);
      i_tx_start = 1'b0;
      repeat (175) step(1);
      build_expect(0, '{1, 0, 1, 0, 0, 1, 0, 1}, 8, -1, 16);
      compare_waves("8n1", 176);
      // Done pulse seen after E160, so the FIFO pops on E161.
      d = first_done(176);
      n_checks++;
      if (d + 1 !== 161) $display("FAIL 8n1_done_edge: pop edge %0d expected 161", d + 1); else n_pass++;
      n_checks++;
      if (busy_log[175] !== 1'b0) $display("FAIL 8n1_busy_after: got %b expected 0", busy_log[175]); else n_pass++;
      $display("frame 8N1 data=a5 pop edge %0d", d + 1);
   endtask

   task automatic test_7e1();
      start_frame(8'h35, 2'b01, 2'b00, 2'b01, 1);
      step(1);
      i_tx_start = 1'b0;
      repeat (175) step(1);
      // 0x35 LSB first over 7 bits: four ones -> even parity bit 0.
      build_expect(0, '{1, 0, 1, 0, 1, 1, 0, 0}, 7, 0, 16);
      compare_waves("7e1", 176);
      $display("frame 7E1 data=35 done at log %0d", first_done(176));
   endtask

   task automatic test_6o2();
      start_frame(8'hFF, 2'b00, 2'b10, 2'b10, 1);
      step(1);
      i_tx_start = 1'b0;
      repeat (175) step(1);
      // Six ones -> odd parity bit 1; 32 stop ticks; bits 6-7 never sent.
      build_expect(0, '{1, 1, 1, 1, 1, 1, 0, 0}, 6, 1, 32);
      compare_waves("6o2", 176);
      $display("frame 6O2 data=ff done at log %0d", first_done(176));
   endtask

   task automatic test_8n15_cfg_change();
      int rise;
      int d;
      int n_done;
      start_frame(8'h00, 2'b10, 2'b01, 2'b00, 4);
      step(4);
      i_tx_start = 1'b0;
      while (cyc < 700) begin
         step(4);
         if (cyc == 200) begin
            i_data     = 8'hFF;
            i_par      = 2'b01;
            i_stop_num = 2'b10;
         end
      end
      rise = -1;
      for (int k = 1; k < 700; k++) begin
         if (rise < 0 && tx_log[k] === 1'b1) rise = k;
      end
      d = first_done(700);
      n_done = 0;
      for (int k = 0; k < 700; k++) if (done_log[k] === 1'b1) n_done++;
      // Ticks on E4, E8, ...: start+8 data = 9*64 low clocks from log 1.
      n_checks++;
      if (rise !== 577) $display("FAIL 8n15_rise: line rises at %0d expected 577", rise); else n_pass++;
      n_checks++;
      if (d - rise + 1 !== 96) $display("FAIL 8n15_stop_len: stop %0d clocks expected 96", d - rise + 1); else n_pass++;
      n_checks++;
      if (n_done !== 1) $display("FAIL 8n15_done_count: got %0d expected 1", n_done); else n_pass++;
      n_checks++;
      if (busy_log[699] !== 1'b0) $display("FAIL 8n15_busy_after: got %b expected 0", busy_log[699]); else n_pass++;
      $display("frame 8N1.5 data=00 tick/4 stop %0d clocks", d - rise + 1);
   endtask

   task automatic test_back_to_back();
      int d1;
      int d2;
      int run;
      start_frame(8'h55, 2'b10, 2'b00, 2'b00, 1);
      step(1);
      i_data = 8'h0F;          // next character, latched when frame 2 starts
      while (cyc < 162) step(1);
      i_tx_start = 1'b0;       // frame 2 already started on E161
      while (cyc < 340) step(1);
      build_expect(0,   '{1, 0, 1, 0, 1, 0, 1, 0}, 8, -1, 16);
      build_expect(161, '{1, 1, 1, 1, 0, 0, 0, 0}, 8, -1, 16);
      compare_waves("b2b", 340);
      d1 = first_done(340);
      d2 = -1;
      for (int k = d1 + 1; k < 340; k++) if (d2 < 0 && done_log[k] === 1'b1) d2 = k;
      n_checks++;
      if (d2 - d1 !== 161) $display("FAIL b2b_done_sep: %0d clocks expected 161", d2 - d1); else n_pass++;
      // 16 stop clocks plus exactly one idle clock before the next start bit.
      run = 0;
      for (int k = 161; k > 0; k--) begin
         if (tx_log[k] === 1'b1) run++;
         else break;
      end
      n_checks++;
      if (run !== 17) $display("FAIL b2b_gap: high run %0d expected 17", run); else n_pass++;
      $display("frames 8N1 data=55,0f done at log %0d and %0d", d1, d2);
   endtask

   task automatic test_reset_mid();
      int n_done;
      start_frame(8'hA5, 2'b10, 2'b00, 2'b00, 1);
      step(1);                 // i_tx_start stays high throughout
      while (cyc < 71) step(1);
      n_checks++;
      if (tx_log[70] !== 1'b0) $display("FAIL rstmid_pre_tx: got %b expected 0", tx_log[70]); else n_pass++;
      #2;
      i_reset = 1'b1;
      #1;
      n_checks++;
      if (o_tx !== 1'b1) $display("FAIL rstmid_async_tx: got %b expected 1", o_tx); else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL rstmid_async_busy: got %b expected 0", o_busy); else n_pass++;
      repeat (3) step(1);
      n_done = 0;
      for (int k = 0; k < cyc; k++) if (done_log[k] === 1'b1) n_done++;
      n_checks++;
      if (n_done !== 0) $display("FAIL rstmid_no_done: %0d done pulses expected 0", n_done); else n_pass++;
      i_reset = 1'b0;
      cyc = 0;
      clear_expect();
      step(1);
      i_tx_start = 1'b0;
      repeat (175) step(1);
      build_expect(0, '{1, 0, 1, 0, 0, 1, 0, 1}, 8, -1, 16);
      compare_waves("rstmid_restart", 176);
      $display("frame 8N1 data=a5 aborted by reset, resent, done at log %0d", first_done(176));
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      cyc         = 0;
      i_reset     = 1'b1;
      i_baud_tick = 1'b0;
      i_tx_start  = 1'b0;
      i_data      = 8'h00;
      i_data_num  = 2'b10;
      i_stop_num  = 2'b00;
      i_par       = 2'b00;
      test_reset();
      test_8n1();
      test_7e1();
      test_6o2();
      test_8n15_cfg_change();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
